peripheral_interrupt_trap_bridge: RTL and testbench
===================================================

Name: peripheral_interrupt_trap_bridge

Overview:
Sits directly downstream of the peripheral interrupt queue and upstream of the core trap logic.
- Consumes one queued cause at a time over the p_int / p_int_read / csr_busy handshake.
- Holds the cause as a trap request until the core acknowledges it.
- Blocks further peripheral interrupts until the handler executes mret and a programmable holdoff expires.

Parameters:
HOLDOFF_CYCLES, 2, idle cycles after mret before the next cause may be accepted (0 allowed)
CNT_W, 16, width of saturating taken-interrupt counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
p_int  input  1  queue presents a valid cause
p_mcause  input  32  cause code from queue, valid while p_int=1
p_int_read  output  1  one-cycle pulse: cause consumed, queue may advance
csr_busy  output  1  tells queue not to present / to withdraw a presentation
mie_global  input  1  mstatus.MIE
meie  input  1  machine external interrupt enable
other_trap_pending  input  1  core has an exception or higher-priority trap this cycle
core_intr_req  output  1  trap request to core
core_intr_cause  output  32  mcause value for core, {1'b1, cause[30:0]}
core_intr_ack  input  1  one-cycle pulse: core entered trap for this request
mret  input  1  one-cycle pulse: core executed mret
taken_count  output  CNT_W  saturating count of acknowledged requests

Behaviour:
Reset (synchronous, active-high):
- state=IDLE; held cause=0; holdoff counter=0.
- p_int_read=0, core_intr_req=0, core_intr_cause=0, taken_count=0.
- Reset mid-operation drops any held cause; that cause is not replayed.

FSM with states IDLE, REQUEST, IN_HANDLER, HOLDOFF.

csr_busy (combinational):
- IDLE: other_trap_pending | ~mie_global | ~meie.
- All other states: 1.

IDLE:
- If p_int=1 and csr_busy=0: capture p_mcause, drive p_int_read=1 for exactly this one cycle, next state REQUEST.
- p_int_read is never asserted outside IDLE and never on two consecutive cycles.

REQUEST:
- core_intr_req=1 (registered, first high the cycle after capture).
- core_intr_cause={1'b1, held[30:0]}, stable for the whole state.
- Stays in REQUEST until core_intr_ack=1, then IN_HANDLER and taken_count increments, saturating at all-ones.
- Dropping mie_global or meie does not cancel the request: the cause is already dequeued and must not be lost.
- mret in this state is ignored.

IN_HANDLER:
- core_intr_req=0.
- On mret=1: go to HOLDOFF with the counter loaded to HOLDOFF_CYCLES, or go straight to IDLE if HOLDOFF_CYCLES=0.
- core_intr_ack in this state is ignored.

HOLDOFF:
- Counter decrements each cycle; when it reaches 1, the next state is IDLE.
- p_int is ignored throughout.

Other rules:
- Simultaneous core_intr_ack and mret in REQUEST: only the ack is honoured.
- Latency from p_int (with csr_busy=0 in IDLE) to p_int_read: same cycle. To core_intr_req: 1 cycle.
- Minimum gap between two p_int_read pulses: 3 + HOLDOFF_CYCLES cycles (ack and mret each at least one cycle).

Test Plan:
1. Reset, mie_global=meie=1, p_int=1, p_mcause=13 → p_int_read pulse that cycle; next cycle core_intr_req=1, core_intr_cause=0x8000000D; ack → req=0, taken_count=1.
2. In IDLE set other_trap_pending=1 with p_int=1 → csr_busy=1, no p_int_read; deassert → p_int_read on that cycle.
3. meie=0 with p_int=1 for 10 cycles → csr_busy=1, p_int_read never pulses; meie=1 → cause 12 captured, core_intr_cause=0x8000000C.
4. In REQUEST drop mie_global and hold ack off for 20 cycles → req stays 1 with cause unchanged; ack → IN_HANDLER.
5. HOLDOFF_CYCLES=2: mret then p_int=1 immediately → no p_int_read for 2 cycles; pulse occurs on the first IDLE cycle. Repeat with HOLDOFF_CYCLES=0 → IDLE the cycle after mret.
6. Assert reset during REQUEST → next cycle req=0, state IDLE, taken_count=0. Drive 2^CNT_W+3 acks → taken_count saturates at all-ones.

Source files
------------

// File: rtl/peripheral_interrupt_trap_bridge.sv
// Bridges the peripheral interrupt queue to the core trap logic: takes one cause,
// holds it as a trap request until acknowledged, then blocks until mret plus a holdoff.
module peripheral_interrupt_trap_bridge #(
  parameter int HOLDOFF_CYCLES = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_int,
  input  logic [31:0]      p_mcause,
  output logic             p_int_read,
  output logic             csr_busy,
  input  logic             mie_global,
  input  logic             meie,
  input  logic             other_trap_pending,
  output logic             core_intr_req,
  output logic [31:0]      core_intr_cause,
  input  logic             core_intr_ack,
  input  logic             mret,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {IDLE, REQUEST, IN_HANDLER, HOLDOFF} state_t;

  localparam int HW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    csr_busy = 1'b1;
    if (state == IDLE)
      csr_busy = other_trap_pending | ~mie_global | ~meie;
  end

  // The dequeue pulse is same-cycle; masking with reset keeps a cause from being
  // consumed on a cycle whose capture the reset would discard.
  assign accept     = (state == IDLE) & p_int & ~csr_busy & ~reset;
  assign p_int_read = accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      core_intr_req   <= 1'b0;
      core_intr_cause <= '0;
      taken_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state           <= REQUEST;
            core_intr_req   <= 1'b1;
            core_intr_cause <= p_mcause | 32'h8000_0000;
          end
        end
        REQUEST: begin
          // Enable changes cannot cancel here: the cause has already left the queue.
          if (core_intr_ack) begin
            state         <= IN_HANDLER;
            core_intr_req <= 1'b0;
            taken_count   <= sat_inc(taken_count);
          end
        end
        IN_HANDLER: begin
          if (mret) begin
            if (HOLDOFF_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state    <= HOLDOFF;
              hold_cnt <= HOLD_LOAD;
            end
          end
        end
        HOLDOFF: begin
          hold_cnt <= hold_cnt - HW'(1);
          if (hold_cnt <= HW'(1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_interrupt_trap_bridge.sv
// Bench for peripheral_interrupt_trap_bridge: two instances (holdoff 2 / 16-bit count,
// holdoff 0 / 3-bit count), a behavioural model, per-cycle compare plus literal checks.
module tb_peripheral_interrupt_trap_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        p_int = 1'b0;
  logic [31:0] p_mcause = '0;
  logic        mie_global = 1'b0;
  logic        meie = 1'b0;
  logic        other_trap_pending = 1'b0;
  logic        core_intr_ack = 1'b0;
  logic        mret = 1'b0;

  logic        p_int_a, p_int_b;
  logic        read_a, read_b, busy_a, busy_b, req_a, req_b;
  logic [31:0] cause_a, cause_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  logic        s_read, s_busy, s_req;
  logic [31:0] s_cause;
  logic [15:0] s_count;

  int nchecks = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign p_int_a = p_int & ~sel;
  assign p_int_b = p_int & sel;

  peripheral_interrupt_trap_bridge #(.HOLDOFF_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .p_int(p_int_a), .p_mcause(p_mcause),
    .p_int_read(read_a), .csr_busy(busy_a), .mie_global(mie_global), .meie(meie),
    .other_trap_pending(other_trap_pending), .core_intr_req(req_a),
    .core_intr_cause(cause_a), .core_intr_ack(core_intr_ack), .mret(mret),
    .taken_count(cnt_a)
  );

  peripheral_interrupt_trap_bridge #(.HOLDOFF_CYCLES(0), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .p_int(p_int_b), .p_mcause(p_mcause),
    .p_int_read(read_b), .csr_busy(busy_b), .mie_global(mie_global), .meie(meie),
    .other_trap_pending(other_trap_pending), .core_intr_req(req_b),
    .core_intr_cause(cause_b), .core_intr_ack(core_intr_ack), .mret(mret),
    .taken_count(cnt_b)
  );

  assign s_read  = sel ? read_b  : read_a;
  assign s_busy  = sel ? busy_b  : busy_a;
  assign s_req   = sel ? req_b   : req_a;
  assign s_cause = sel ? cause_b : cause_a;
  assign s_count = sel ? {13'b0, cnt_b} : cnt_a;

  // Model: a cause is either outstanding, being handled, or the bridge is blocked
  // for a number of remaining cycles; otherwise it is free to accept.
  bit          started = 1'b0;
  bit          m_req = 1'b0;
  bit          m_handler = 1'b0;
  int          m_block = 0;
  logic [31:0] m_cause = '0;
  int          m_count = 0;

  function automatic bit m_free();
    return !m_req && !m_handler && (m_block == 0);
  endfunction

  function automatic bit exp_busy();
    return m_free() ? (other_trap_pending || !mie_global || !meie) : 1'b1;
  endfunction

  function automatic bit exp_read();
    return m_free() && p_int && !exp_busy() && !reset;
  endfunction

  always @(posedge clk) begin
    int h, mx;
    h  = sel ? 0 : 2;
    mx = sel ? 7 : 65535;
    if (reset) begin
      started = 1'b1;
      m_req = 1'b0; m_handler = 1'b0; m_block = 0; m_cause = '0; m_count = 0;
    end else if (exp_read()) begin
      m_req = 1'b1;
      m_cause = {1'b1, p_mcause[30:0]};
    end else if (m_req) begin
      if (core_intr_ack) begin
        m_req = 1'b0;
        m_handler = 1'b1;
        m_count = (m_count < mx) ? m_count + 1 : mx;
      end
    end else if (m_handler) begin
      if (mret) begin
        m_handler = 1'b0;
        m_block = h;
      end
    end else if (m_block > 0) begin
      m_block = m_block - 1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("model_p_int_read", {31'b0, s_read}, {31'b0, exp_read()});
      cmp("model_csr_busy", {31'b0, s_busy}, {31'b0, exp_busy()});
      cmp("model_core_intr_req", {31'b0, s_req}, {31'b0, m_req});
      if (m_req) cmp("model_core_intr_cause", s_cause, m_cause);
      cmp("model_taken_count", {16'b0, s_count}, m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int h);
    core_intr_ack = 1'b1; step(); core_intr_ack = 1'b0;
    mret = 1'b1; step(); mret = 1'b0;
    repeat (h) step();
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    cmp("reset_req", {31'b0, s_req}, 0);
    cmp("reset_count", {16'b0, s_count}, 0);
    cmp("reset_cause", s_cause, 0);
    cmp("reset_read", {31'b0, s_read}, 0);

    // Basic capture, request, ack
    step();
    mie_global = 1'b1; meie = 1'b1; p_mcause = 32'd13; p_int = 1'b1;
    @(negedge clk); cmp("t1_read", {31'b0, s_read}, 1);
    step(); p_int = 1'b0;
    @(negedge clk); cmp("t1_req", {31'b0, s_req}, 1);
    cmp("t1_cause", s_cause, 32'h8000_000D);
    step(); core_intr_ack = 1'b1; step(); core_intr_ack = 1'b0;
    @(negedge clk); cmp("t1_req_off", {31'b0, s_req}, 0);
    cmp("t1_count", {16'b0, s_count}, 1);

    // mret with p_int waiting: two holdoff cycles before the pulse
    step(); mret = 1'b1; p_int = 1'b1; p_mcause = 32'd5;
    step(); mret = 1'b0;
    @(negedge clk); cmp("t5_hold1_read", {31'b0, s_read}, 0);
    step(); @(negedge clk); cmp("t5_hold2_read", {31'b0, s_read}, 0);
    step(); @(negedge clk); cmp("t5_idle_read", {31'b0, s_read}, 1);
    step(); p_int = 1'b0; serve(2);

    // other_trap_pending blocks acceptance
    other_trap_pending = 1'b1; p_int = 1'b1; p_mcause = 32'd7;
    @(negedge clk); cmp("t2_busy", {31'b0, s_busy}, 1);
    cmp("t2_read_blocked", {31'b0, s_read}, 0);
    step(); step(); other_trap_pending = 1'b0;
    @(negedge clk); cmp("t2_read", {31'b0, s_read}, 1);
    step(); p_int = 1'b0; serve(2);

    // meie low for 10 cycles
    meie = 1'b0; p_int = 1'b1; p_mcause = 32'd12;
    repeat (10) begin
      @(negedge clk); cmp("t3_read_blocked", {31'b0, s_read}, 0);
      step();
    end
    meie = 1'b1;
    @(negedge clk); cmp("t3_read", {31'b0, s_read}, 1);
    step(); p_int = 1'b0;
    @(negedge clk); cmp("t3_cause", s_cause, 32'h8000_000C);

    // Request survives mie_global drop and a long ack delay
    mie_global = 1'b0;
    repeat (20) begin
      step();
      @(negedge clk); cmp("t4_req_held", {31'b0, s_req}, 1);
      cmp("t4_cause_held", s_cause, 32'h8000_000C);
    end
    step(); core_intr_ack = 1'b1; step(); core_intr_ack = 1'b0; mie_global = 1'b1;
    @(negedge clk); cmp("t4_req_off", {31'b0, s_req}, 0);
    cmp("t4_count", {16'b0, s_count}, 4);
    mret = 1'b1; step(); mret = 1'b0; step(); step();

    // mret during REQUEST ignored; ack together with mret honours only the ack
    p_int = 1'b1; p_mcause = 32'd9; step(); p_int = 1'b0;
    mret = 1'b1; step();
    core_intr_ack = 1'b1; step(); core_intr_ack = 1'b0; mret = 1'b0;
    @(negedge clk); cmp("ackmret_count", {16'b0, s_count}, 5);
    p_int = 1'b1;
    @(negedge clk); cmp("handler_read_blocked", {31'b0, s_read}, 0);
    step(); mret = 1'b1; step(); mret = 1'b0; p_int = 1'b0; step(); step();

    // Reset during REQUEST drops the cause
    p_int = 1'b1; p_mcause = 32'd3; step(); p_int = 1'b0;
    @(negedge clk); cmp("t6_req_before", {31'b0, s_req}, 1);
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge clk); cmp("t6_req_cleared", {31'b0, s_req}, 0);
    cmp("t6_count_cleared", {16'b0, s_count}, 0);
    cmp("t6_idle_busy", {31'b0, s_busy}, 0);

    // Zero-holdoff instance
    step(); reset = 1'b1; sel = 1'b1; step(); reset = 1'b0;
    p_int = 1'b1; p_mcause = 32'd21; step(); p_int = 1'b0;
    core_intr_ack = 1'b1; step(); core_intr_ack = 1'b0;
    mret = 1'b1; p_int = 1'b1; p_mcause = 32'd22;
    @(negedge clk); cmp("t5b_handler_read", {31'b0, s_read}, 0);
    step(); mret = 1'b0;
    @(negedge clk); cmp("t5b_idle_read", {31'b0, s_read}, 1);
    step(); p_int = 1'b0;
    @(negedge clk); cmp("t5b_cause", s_cause, 32'h8000_0016);
    serve(0);

    // Saturation of the 3-bit count: 2 + 11 acks clamp at 7
    for (int i = 0; i < 11; i++) begin
      p_int = 1'b1; p_mcause = 32'(i); step(); p_int = 1'b0;
      serve(0);
    end
    @(negedge clk); cmp("t6_count_sat", {16'b0, s_count}, 7);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
